// File: rtl/agg_pkg.sv
// Shared types and helpers for the flex_aggregator serial-to-parallel packer.
// Package defaults mirror the module parameter defaults.
package agg_pkg;

    localparam int AGG_DATA_WIDTH      = 8;
    localparam int AGG_MAX_FETCH_WIDTH = 4;
    localparam int AGG_CNT_W           = $clog2(AGG_MAX_FETCH_WIDTH + 1);

    typedef logic [AGG_CNT_W-1:0] lane_cnt_t;

    function automatic logic legal_width(input int unsigned w,
                                         input int unsigned max_w = AGG_MAX_FETCH_WIDTH);
        return (w >= 1) && (w <= max_w);
    endfunction

endpackage

// File: rtl/agg_out_buf.sv
// One-entry output register: holds a packed word and lane count until the receiver takes it.
// Load wins over enq, so a drain and a refill in the same cycle keep the buffer valid.
module agg_out_buf #(
    parameter int DW = 32,
    parameter int CW = 3
) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic [CW-1:0] i_cnt,
    input  logic          i_enq,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_cnt,
    output logic          o_v
);

    logic [DW-1:0] r_data;
    logic [CW-1:0] r_cnt;
    logic          r_v;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_v    <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= i_cnt;
            r_v    <= 1'b1;
        end else if (i_enq) begin
            r_v    <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;
    assign o_v    = r_v;

endmodule

// File: rtl/flex_aggregator.sv
// Packs FWFT sender words into 1..MAX_FETCH_WIDTH-lane words; last pop in cycle N can enq in N+1.
// A full, stalled output buffer blocks only the completing pop; width changes cost one bubble.
module flex_aggregator
    import agg_pkg::*;
#(
    parameter int DATA_WIDTH      = AGG_DATA_WIDTH,
    parameter int MAX_FETCH_WIDTH = AGG_MAX_FETCH_WIDTH,
    parameter int CNT_W           = $clog2(MAX_FETCH_WIDTH + 1)
) (
    input  logic                                  wclk,
    input  logic                                  wrst_n,
    input  logic [DATA_WIDTH-1:0]                 sender_data,
    input  logic                                  sender_empty_n,
    output logic                                  sender_deq,
    output logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
    output logic [CNT_W-1:0]                      receiver_count,
    input  logic                                  receiver_full_n,
    output logic                                  receiver_enq,
    input  logic [CNT_W-1:0]                      input_fetch_width,
    input  logic                                  change_fetch_width,
    input  logic                                  flush,
    output logic                                  busy,
    output logic                                  cfg_error
);

    localparam int PW = MAX_FETCH_WIDTH * DATA_WIDTH;

    logic [CNT_W-1:0] r_fw;
    logic [CNT_W-1:0] r_pend_fw;
    logic             r_pend_v;
    logic [CNT_W-1:0] r_idx;
    logic [PW-1:0]    r_pack;
    logic             r_flush_p;
    logic             r_cfg_error;

    logic             w_out_v;
    logic [PW-1:0]    w_out_data;
    logic [CNT_W-1:0] w_out_cnt;
    logic             w_enq;
    logic             w_buf_free;
    logic             w_idx_zero;
    logic             w_last;
    logic             w_deq;
    logic             w_flush_load;
    logic             w_load;
    logic [PW-1:0]    w_pack_next;
    logic [PW-1:0]    w_load_data;
    logic [CNT_W-1:0] w_load_cnt;
    logic             w_req_legal;

    always_comb begin
        w_enq        = wrst_n & w_out_v & receiver_full_n;
        w_buf_free   = !w_out_v | w_enq;
        w_idx_zero   = (r_idx == '0);
        w_last       = (r_idx == r_fw - CNT_W'(1));
        // Pending flush and pending width change both hold off popping.
        w_deq        = wrst_n & sender_empty_n & !r_flush_p
                     & !(r_pend_v & w_idx_zero) & !(w_last & !w_buf_free);
        w_flush_load = r_flush_p & !w_idx_zero & w_buf_free;
        w_load       = wrst_n & ((w_deq & w_last) | w_flush_load);
        w_req_legal  = legal_width(32'(input_fetch_width), MAX_FETCH_WIDTH);
    end

    always_comb begin
        w_pack_next = r_pack;
        for (int i = 0; i < MAX_FETCH_WIDTH; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_pack_next[i*DATA_WIDTH +: DATA_WIDTH] = sender_data;
            end
        end
        w_load_data = w_flush_load ? r_pack : w_pack_next;
        w_load_cnt  = w_flush_load ? r_idx  : r_fw;
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_fw        <= CNT_W'(MAX_FETCH_WIDTH);
            r_pend_fw   <= '0;
            r_pend_v    <= 1'b0;
            r_idx       <= '0;
            r_pack      <= '0;
            r_flush_p   <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            if (r_flush_p) begin
                if (w_idx_zero) begin
                    r_flush_p <= 1'b0;
                end else if (w_buf_free) begin
                    r_pack    <= '0;
                    r_idx     <= '0;
                    r_flush_p <= 1'b0;
                end
            end else if (r_pend_v && w_idx_zero) begin
                r_fw     <= r_pend_fw;
                r_pend_v <= 1'b0;
            end else if (w_deq) begin
                // Pack is cleared on completion so unused lanes of later words read zero.
                if (w_last) begin
                    r_pack <= '0;
                    r_idx  <= '0;
                end else begin
                    r_pack <= w_pack_next;
                    r_idx  <= r_idx + CNT_W'(1);
                end
            end

            r_cfg_error <= change_fetch_width & !w_req_legal;
            if (change_fetch_width && w_req_legal) begin
                r_pend_fw <= input_fetch_width;
                r_pend_v  <= 1'b1;
            end
            if (flush) begin
                r_flush_p <= 1'b1;
            end
        end
    end

    agg_out_buf #(
        .DW (PW),
        .CW (CNT_W)
    ) u_out_buf (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .i_load (w_load),
        .i_data (w_load_data),
        .i_cnt  (w_load_cnt),
        .i_enq  (w_enq),
        .o_data (w_out_data),
        .o_cnt  (w_out_cnt),
        .o_v    (w_out_v)
    );

    assign sender_deq     = w_deq;
    assign receiver_enq   = w_enq;
    assign receiver_data  = wrst_n ? w_out_data : '0;
    assign receiver_count = wrst_n ? w_out_cnt  : '0;
    assign busy           = wrst_n & (!w_idx_zero | w_out_v | r_pend_v | r_flush_p);
    assign cfg_error      = wrst_n & r_cfg_error;

endmodule
